// File: rtl/nibbler_sequencer.sv
// Fetch/execute sequencer for the Nibbler 4-bit CPU with run/halt/single-step control.
// Define BREAKPOINT_EN to add the PC-match breakpoint ports (pc, bp_addr, bp_en, bp_hit).
module nibbler_sequencer #(
  parameter int unsigned RETIRE_W = 8
`ifdef BREAKPOINT_EN
  , parameter int unsigned PC_W   = 12
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  input  logic [7:0]          rom_data,
  input  logic                alu_carry,
  input  logic                alu_zero,
  input  logic                notLoadFlags,
`ifdef BREAKPOINT_EN
  input  logic [PC_W-1:0]     pc,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                bp_en,
  output logic                bp_hit,
`endif
  output logic                phaseOut,
  output logic [3:0]          instruction,
  output logic [3:0]          operand,
  output logic [1:0]          flagsOut,
  output logic                exec_en,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_single_shot;
  logic                w_single_shot_nxt;
  logic                r_step_d;
  logic                w_step_rise;
  logic                w_bp_match;
  logic                r_phase;
  logic                r_exec_en;
  logic                r_halted;
  logic [3:0]          r_instruction;
  logic [3:0]          r_operand;
  logic [1:0]          r_flags;
  logic [RETIRE_W-1:0] r_retired;

`ifdef BREAKPOINT_EN
  logic r_bp_hit;
  logic w_bp_hit_nxt;
  assign w_bp_match = bp_en && (pc == bp_addr);
  assign bp_hit     = r_bp_hit;
`else
  assign w_bp_match = 1'b0;
`endif

  assign w_step_rise = step & ~r_step_d;

  // State register; phase/enable/halted are registered copies of the next-state decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_HALTED;
      r_single_shot <= 1'b0;
      r_step_d      <= 1'b0;
      r_phase       <= 1'b0;
      r_exec_en     <= 1'b0;
      r_halted      <= 1'b1;
`ifdef BREAKPOINT_EN
      r_bp_hit      <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_single_shot <= w_single_shot_nxt;
      r_step_d      <= step;
      r_phase       <= (w_state_nxt == S_EXEC);
      r_exec_en     <= (w_state_nxt != S_HALTED);
      r_halted      <= (w_state_nxt == S_HALTED);
`ifdef BREAKPOINT_EN
      r_bp_hit      <= w_bp_hit_nxt;
`endif
    end
  end

  // Next-state: run beats step, a step ignores the breakpoint so it can always move off it
  always_comb begin
    w_state_nxt       = r_state;
    w_single_shot_nxt = r_single_shot;
`ifdef BREAKPOINT_EN
    w_bp_hit_nxt      = r_bp_hit;
`endif
    case (r_state)
      S_HALTED: begin
        if (run && !halt_req && !w_bp_match) begin
          w_state_nxt       = S_FETCH;
          w_single_shot_nxt = 1'b0;
`ifdef BREAKPOINT_EN
          w_bp_hit_nxt      = 1'b0;
`endif
        end else if (w_step_rise) begin
          w_state_nxt       = S_FETCH;
          w_single_shot_nxt = 1'b1;
`ifdef BREAKPOINT_EN
          w_bp_hit_nxt      = 1'b0;
        end else if (run && !halt_req) begin
          w_bp_hit_nxt      = 1'b1;
`endif
        end
      end
      S_FETCH: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (r_single_shot || halt_req || !run) begin
          w_state_nxt       = S_HALTED;
          w_single_shot_nxt = 1'b0;
        end else if (w_bp_match) begin
          w_state_nxt       = S_HALTED;
`ifdef BREAKPOINT_EN
          w_bp_hit_nxt      = 1'b1;
`endif
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt       = S_HALTED;
        w_single_shot_nxt = 1'b0;
      end
    endcase
  end

  // Instruction/operand latch at end of FETCH; flags and retire count at end of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instruction <= 4'd0;
      r_operand     <= 4'd0;
      r_flags       <= 2'b00;
      r_retired     <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_instruction <= rom_data[7:4];
        r_operand     <= rom_data[3:0];
      end
      if (r_state == S_EXEC) begin
        if (!notLoadFlags) begin
          r_flags <= {alu_carry, alu_zero};
        end
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  assign phaseOut    = r_phase;
  assign exec_en     = r_exec_en;
  assign halted      = r_halted;
  assign instruction = r_instruction;
  assign operand     = r_operand;
  assign flagsOut    = r_flags;
  assign retired     = r_retired;

endmodule
